// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-index width, the hardwired zero register
// and the hazard controller state encoding.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StTimeout
    } hazardStateT;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination feeds a source operand of the
// instruction in IF/ID.
module load_use_detect
    import pipe_pkg::ZERO_REG;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             memRead,
    input  logic             regWrite,
    input  logic [REG_W-1:0] dest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             usesRt,
    output logic             hazard
);

    logic destLive;
    logic rsMatch;
    logic rtMatch;

    // r0 is hardwired, so a load targeting it can never produce a dependency
    assign destLive = memRead && regWrite && (dest != REG_W'(ZERO_REG));
    assign rsMatch  = (dest == rs);
    assign rtMatch  = usesRt && (dest == rt);
    assign hazard   = destLive && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives the IF/ID and ID/EX enable/flush/bubble
// controls for load-use stalls, EX redirects and data-memory waits.
module hazard_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [REG_W-1:0] idex_reg_dest,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    import pipe_pkg::hazardStateT;
    import pipe_pkg::StRun;
    import pipe_pkg::StMemWait;
    import pipe_pkg::StTimeout;

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    hazardStateT       stateQ;
    logic [WAIT_W-1:0] waitCntQ;
    logic [CNT_W-1:0]  stallCntQ;
    logic [CNT_W-1:0]  flushCntQ;
    logic              timeoutQ;
    logic              loadUse;
    logic              freeze;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .memRead  (idex_mem_read),
        .regWrite (idex_reg_write),
        .dest     (idex_reg_dest),
        .rs       (ifid_rs),
        .rt       (ifid_rt),
        .usesRt   (ifid_uses_rt),
        .hazard   (loadUse)
    );

    assign freeze = (stateQ == StTimeout) || mem_busy;

    always_comb begin
        pc_write    = 1'b1;
        ifid_enable = 1'b1;
        ifid_flush  = 1'b0;
        idex_enable = 1'b1;
        idex_bubble = 1'b0;
        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
        end else if (ex_redirect) begin
            // Redirect squashes the dependent instruction, so no load-use stall here
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (loadUse) begin
            pc_write    = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= StRun;
            waitCntQ  <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
            timeoutQ  <= 1'b0;
        end else begin
            case (stateQ)
                StTimeout: begin
                    stallCntQ <= satInc(stallCntQ);
                end
                StRun, StMemWait: begin
                    if (mem_busy) begin
                        stallCntQ <= satInc(stallCntQ);
                        if ((stateQ == StMemWait) && (waitCntQ == WAIT_W'(MAX_WAIT))) begin
                            stateQ   <= StTimeout;
                            timeoutQ <= 1'b1;
                        end else begin
                            stateQ   <= StMemWait;
                            waitCntQ <= (stateQ == StRun) ? WAIT_W'(1) : waitCntQ + 1'b1;
                        end
                    end else begin
                        stateQ   <= StRun;
                        waitCntQ <= '0;
                        if (ex_redirect) begin
                            flushCntQ <= satInc(flushCntQ);
                        end else if (loadUse) begin
                            stallCntQ <= satInc(stallCntQ);
                        end
                    end
                end
                default: begin
                    stateQ <= StRun;
                end
            endcase
        end
    end

    assign stall_count = stallCntQ;
    assign flush_count = flushCntQ;
    assign mem_timeout = timeoutQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, squashes, memory waits, timeout,
// asynchronous reset and counter saturation.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  ifid_rs = '0;
    logic [4:0]  ifid_rt = '0;
    logic        ifid_uses_rt = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic        idex_reg_write = 1'b0;
    logic [4:0]  idex_reg_dest = '0;
    logic        ex_redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_write;
    logic        ifid_enable;
    logic        ifid_flush;
    logic        idex_enable;
    logic        idex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic        mem_timeout;
    logic [4:0]  ctrl;

    int total = 0;
    int bad = 0;

    // {pc_write, ifid_enable, ifid_flush, idex_enable, idex_bubble}
    localparam logic [4:0] CtlRun    = 5'b11010;
    localparam logic [4:0] CtlStall  = 5'b00011;
    localparam logic [4:0] CtlSquash = 5'b11111;
    localparam logic [4:0] CtlFreeze = 5'b00000;
    localparam logic [4:0] CtlReset  = 5'b00101;

    assign ctrl = {pc_write, ifid_enable, ifid_flush, idex_enable, idex_bubble};

    always #5 clock = ~clock;

    hazard_ctrl #(
        .REG_W    (5),
        .MAX_WAIT (15),
        .CNT_W    (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rt   (ifid_uses_rt),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .idex_reg_dest  (idex_reg_dest),
        .ex_redirect    (ex_redirect),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .ifid_enable    (ifid_enable),
        .ifid_flush     (ifid_flush),
        .idex_enable    (idex_enable),
        .idex_bubble    (idex_bubble),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout)
    );

    task automatic idle_inputs();
        ifid_rs = '0;
        ifid_rt = '0;
        ifid_uses_rt = 1'b0;
        idex_mem_read = 1'b0;
        idex_reg_write = 1'b0;
        idex_reg_dest = '0;
        ex_redirect = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] dest);
        idex_mem_read = 1'b1;
        idex_reg_write = 1'b1;
        idex_reg_dest = dest;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        total++;
        if (ctrl !== CtlReset) begin
            bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, CtlReset);
        end
        total++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b want=0", mem_timeout);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clock);
        set_load(5'd5); ifid_rs = 5'd5; ifid_rt = 5'd7; ifid_uses_rt = 1'b1;
        #1;
        total++;
        if (ctrl !== CtlStall) begin
            bad++; $display("FAIL load_use_ctrl got=%b want=%b", ctrl, CtlStall);
        end
        @(posedge clock); #1;
        total++;
        if (stall_count !== 16'd1) begin
            bad++; $display("FAIL load_use_count got=%0d want=1", stall_count);
        end
        // the bubble now sits in ID/EX, so the dependent instruction proceeds
        @(negedge clock);
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_reg_dest = '0;
        #1;
        total++;
        if (ctrl !== CtlRun) begin
            bad++; $display("FAIL load_use_release got=%b want=%b", ctrl, CtlRun);
        end
        @(posedge clock); #1;
        total++;
        if (stall_count !== 16'd1) begin
            bad++; $display("FAIL load_use_single got=%0d want=1", stall_count);
        end
    endtask

    task automatic test_no_stall();
        apply_reset();
        @(negedge clock);
        set_load(5'd0); ifid_rs = 5'd0;
        #1;
        total++;
        if (ctrl !== CtlRun) begin
            bad++; $display("FAIL reg0_ctrl got=%b want=%b", ctrl, CtlRun);
        end
        @(negedge clock);
        set_load(5'd5); ifid_rs = 5'd3; ifid_rt = 5'd5; ifid_uses_rt = 1'b0;
        #1;
        total++;
        if (ctrl !== CtlRun) begin
            bad++; $display("FAIL rt_unused_ctrl got=%b want=%b", ctrl, CtlRun);
        end
        @(negedge clock);
        idex_reg_write = 1'b0; ifid_rs = 5'd5;
        #1;
        total++;
        if (ctrl !== CtlRun) begin
            bad++; $display("FAIL no_regwrite_ctrl got=%b want=%b", ctrl, CtlRun);
        end
        @(negedge clock);
        idex_reg_write = 1'b1; ifid_rs = 5'd3; ifid_uses_rt = 1'b1;
        #1;
        total++;
        if (ctrl !== CtlStall) begin
            bad++; $display("FAIL rt_used_ctrl got=%b want=%b", ctrl, CtlStall);
        end
        @(posedge clock); #1;
        total++;
        if (stall_count !== 16'd1) begin
            bad++; $display("FAIL no_stall_count got=%0d want=1", stall_count);
        end
    endtask

    task automatic test_redirect_load_use();
        apply_reset();
        @(negedge clock);
        set_load(5'd5); ifid_rs = 5'd5; ex_redirect = 1'b1;
        #1;
        total++;
        if (ctrl !== CtlSquash) begin
            bad++; $display("FAIL redirect_ctrl got=%b want=%b", ctrl, CtlSquash);
        end
        @(posedge clock); #1;
        total++;
        if (flush_count !== 16'd1 || stall_count !== 16'd0) begin
            bad++; $display("FAIL redirect_counts got=%0d/%0d want=1/0", flush_count, stall_count);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_busy = 1'b1; ex_redirect = 1'b1;
            #1;
            total++;
            if (ctrl !== CtlFreeze) begin
                bad++; $display("FAIL mem_wait_freeze%0d got=%b want=%b", i, ctrl, CtlFreeze);
            end
        end
        @(negedge clock);
        mem_busy = 1'b0;
        #1;
        total++;
        if (stall_count !== 16'd3 || flush_count !== 16'd0) begin
            bad++; $display("FAIL mem_wait_counts got=%0d/%0d want=3/0", stall_count, flush_count);
        end
        total++;
        if (ctrl !== CtlSquash) begin
            bad++; $display("FAIL mem_wait_release got=%b want=%b", ctrl, CtlSquash);
        end
        @(posedge clock); #1;
        total++;
        if (flush_count !== 16'd1 || stall_count !== 16'd3) begin
            bad++; $display("FAIL mem_wait_redirect got=%0d/%0d want=1/3", flush_count, stall_count);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (15) begin
            @(negedge clock);
            mem_busy = 1'b1;
            @(posedge clock);
        end
        #1;
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_early got=%b want=0", mem_timeout);
        end
        @(posedge clock); #1;
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_set got=%b want=1", mem_timeout);
        end
        @(negedge clock);
        mem_busy = 1'b0;
        #1;
        total++;
        if (ctrl !== CtlFreeze) begin
            bad++; $display("FAIL timeout_freeze got=%b want=%b", ctrl, CtlFreeze);
        end
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (ctrl !== CtlFreeze || mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got=%b/%b want=%b/1", ctrl, mem_timeout, CtlFreeze);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        @(negedge clock);
        mem_busy = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (ctrl !== CtlReset) begin
            bad++; $display("FAIL midwait_ctrl got=%b want=%b", ctrl, CtlReset);
        end
        total++;
        if (stall_count !== 16'd0) begin
            bad++; $display("FAIL midwait_count got=%0d want=0", stall_count);
        end
        @(negedge clock);
        reset_n = 1'b1; mem_busy = 1'b0;
        #1;
        total++;
        if (ctrl !== CtlRun) begin
            bad++; $display("FAIL midwait_run got=%b want=%b", ctrl, CtlRun);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        @(negedge clock);
        set_load(5'd9); ifid_rs = 5'd9;
        repeat (65540) @(posedge clock);
        #1;
        total++;
        if (stall_count !== 16'hFFFF || flush_count !== 16'd0) begin
            bad++; $display("FAIL saturate got=%h/%h want=ffff/0000", stall_count, flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
